// File: rtl/fetch_pc_unit.sv
// rtl/fetch_pc_unit.sv - fetch PC generation with one-entry redirect buffer and IF/ID register
module fetch_pc_unit #(
    parameter logic [31:0] RESET_PC  = 32'h00000000,
    parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        StallF,
    input  logic        StallD,
    input  logic        FlushD,
    input  logic        FlushD_BP,
    input  logic        Taken,
    input  logic [31:0] P_PC,
    input  logic        MispredE,
    input  logic [31:0] PCRecoverE,
    input  logic [31:0] InstrF,
    output logic [31:0] PCF,
    output logic [31:0] PCD,
    output logic [31:0] PCPlus4D,
    output logic [31:0] InstrD,
    output logic        ValidD,
    output logic [15:0] MispredCnt,
    output logic [15:0] PredCnt
);

    logic [31:0] pcf_q, pcf_d;
    logic [31:0] pcd_q, pcd_d;
    logic [31:0] pc4d_q, pc4d_d;
    logic [31:0] instrd_q, instrd_d;
    logic        validd_q, validd_d;
    logic        pendv_q, pendv_d;
    logic [31:0] pendpc_q, pendpc_d;
    logic [15:0] mcnt_q, mcnt_d;
    logic [15:0] pcnt_q, pcnt_d;

    logic        pred_req;
    logic        squash_d;
    logic        redirect_applied;
    logic [31:0] pcf_plus4;

    always_comb begin
        pred_req         = Taken & validd_q;
        pcf_plus4        = pcf_q + 32'd4;
        squash_d         = FlushD | FlushD_BP | MispredE | (pred_req & !StallF) | (pendv_q & !StallF);
        redirect_applied = !MispredE && !StallF && (pendv_q || pred_req);

        pcf_d    = pcf_q;
        pendv_d  = pendv_q;
        pendpc_d = pendpc_q;
        pcd_d    = pcd_q;
        pc4d_d   = pc4d_q;
        instrd_d = instrd_q;
        validd_d = validd_q;
        mcnt_d   = mcnt_q;
        pcnt_d   = pcnt_q;

        // A buffered target is older than any new prediction, so it wins.
        if (MispredE) begin
            pcf_d = PCRecoverE;
        end else if (pendv_q && !StallF) begin
            pcf_d = pendpc_q;
        end else if (pred_req && !StallF) begin
            pcf_d = P_PC;
        end else if (!StallF) begin
            pcf_d = pcf_plus4;
        end

        if (MispredE) begin
            pendv_d = 1'b0;
        end else if (pendv_q && !StallF) begin
            pendv_d = 1'b0;
        end else if (pred_req && StallF && !pendv_q) begin
            pendv_d  = 1'b1;
            pendpc_d = P_PC;
        end

        if (squash_d) begin
            instrd_d = NOP_INSTR;
            validd_d = 1'b0;
        end else if (!StallD) begin
            instrd_d = InstrF;
            pcd_d    = pcf_q;
            pc4d_d   = pcf_plus4;
            validd_d = 1'b1;
        end

        if (MispredE && mcnt_q != 16'hFFFF) begin
            mcnt_d = mcnt_q + 16'd1;
        end
        if (redirect_applied && pcnt_q != 16'hFFFF) begin
            pcnt_d = pcnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pcf_q    <= RESET_PC;
            pcd_q    <= 32'd0;
            pc4d_q   <= 32'd0;
            instrd_q <= NOP_INSTR;
            validd_q <= 1'b0;
            pendv_q  <= 1'b0;
            pendpc_q <= 32'd0;
            mcnt_q   <= 16'd0;
            pcnt_q   <= 16'd0;
        end else begin
            pcf_q    <= pcf_d;
            pcd_q    <= pcd_d;
            pc4d_q   <= pc4d_d;
            instrd_q <= instrd_d;
            validd_q <= validd_d;
            pendv_q  <= pendv_d;
            pendpc_q <= pendpc_d;
            mcnt_q   <= mcnt_d;
            pcnt_q   <= pcnt_d;
        end
    end

    assign PCF        = pcf_q;
    assign PCD        = pcd_q;
    assign PCPlus4D   = pc4d_q;
    assign InstrD     = instrd_q;
    assign ValidD     = validd_q;
    assign MispredCnt = mcnt_q;
    assign PredCnt    = pcnt_q;

endmodule

// File: tb/tb_fetch_pc_unit.sv
// tb/tb_fetch_pc_unit.sv - scoreboard bench for fetch_pc_unit
module tb_fetch_pc_unit;

    localparam logic [31:0] NOP = 32'h00000013;

    logic        clk = 1'b0;
    logic        rst_n, StallF, StallD, FlushD, FlushD_BP, Taken, MispredE;
    logic [31:0] P_PC, PCRecoverE, InstrF;
    logic [31:0] PCF, PCD, PCPlus4D, InstrD;
    logic        ValidD;
    logic [15:0] MispredCnt, PredCnt;

    fetch_pc_unit dut (
        .clk(clk), .rst_n(rst_n), .StallF(StallF), .StallD(StallD),
        .FlushD(FlushD), .FlushD_BP(FlushD_BP), .Taken(Taken), .P_PC(P_PC),
        .MispredE(MispredE), .PCRecoverE(PCRecoverE), .InstrF(InstrF),
        .PCF(PCF), .PCD(PCD), .PCPlus4D(PCPlus4D), .InstrD(InstrD),
        .ValidD(ValidD), .MispredCnt(MispredCnt), .PredCnt(PredCnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pcf, pcd, pc4d, instrd;
        logic        valid;
        logic [15:0] mc, pc;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int checks = 0;
    int failures = 0;

    logic [31:0] m_pc, m_pcd, m_pc4d, m_instrd, m_pendpc;
    logic        m_valid, m_pendv;
    logic [15:0] m_mc, m_pcnt;

    function automatic logic [31:0] imem(input logic [31:0] a);
        return {a[15:0], 16'hC0DE} ^ 32'h5A000000;
    endfunction

    // Advance one clock: compute reference next state from the inputs now driven, push it, sample after the edge.
    task automatic step();
        logic        pred, sq;
        logic [31:0] npc;
        InstrF = imem(m_pc);
        if (!rst_n) begin
            m_pc = 32'd0; m_pcd = 32'd0; m_pc4d = 32'd0; m_instrd = NOP;
            m_valid = 1'b0; m_pendv = 1'b0; m_pendpc = 32'd0; m_mc = 16'd0; m_pcnt = 16'd0;
        end else begin
            pred = Taken && m_valid;
            sq   = FlushD || FlushD_BP || MispredE || (pred && !StallF) || (m_pendv && !StallF);
            if (MispredE)                 npc = PCRecoverE;
            else if (StallF)              npc = m_pc;
            else if (m_pendv)             npc = m_pendpc;
            else if (pred)                npc = P_PC;
            else                          npc = m_pc + 32'd4;
            if (!MispredE && !StallF && (m_pendv || pred) && m_pcnt != 16'hFFFF) m_pcnt = m_pcnt + 16'd1;
            if (MispredE && m_mc != 16'hFFFF) m_mc = m_mc + 16'd1;
            if (sq) begin
                m_instrd = NOP; m_valid = 1'b0;
            end else if (!StallD) begin
                m_instrd = InstrF; m_pcd = m_pc; m_pc4d = m_pc + 32'd4; m_valid = 1'b1;
            end
            if (MispredE || (m_pendv && !StallF)) m_pendv = 1'b0;
            else if (pred && StallF && !m_pendv) begin m_pendv = 1'b1; m_pendpc = P_PC; end
            m_pc = npc;
        end
        sb.push_back('{m_pc, m_pcd, m_pc4d, m_instrd, m_valid, m_mc, m_pcnt});
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        StallF = 0; StallD = 0; FlushD = 0; FlushD_BP = 0; Taken = 0; MispredE = 0;
        P_PC = 32'd0; PCRecoverE = 32'd0;
    endtask

    task automatic test_reset();
        rst_n = 0; StallF = 1; StallD = 1; FlushD = 1; Taken = 1; MispredE = 1;
        P_PC = 32'h777; PCRecoverE = 32'h999;
        step(); step();
        e = sb.pop_front(); e = sb.pop_front();
        checks++; if (PCF !== 32'd0 || PCF !== e.pcf) begin failures++; $display("FAIL reset_pcf got=%h exp=%h", PCF, e.pcf); end
        checks++; if ({PCD, PCPlus4D} !== 64'd0) begin failures++; $display("FAIL reset_pcd got=%h/%h exp=0/0", PCD, PCPlus4D); end
        checks++; if (InstrD !== NOP || ValidD !== 1'b0) begin failures++; $display("FAIL reset_instrd got=%h v=%b exp=%h v=0", InstrD, ValidD, NOP); end
        checks++; if ({MispredCnt, PredCnt} !== 32'd0) begin failures++; $display("FAIL reset_cnt got=%h/%h exp=0/0", MispredCnt, PredCnt); end
    endtask

    task automatic test_sequential();
        idle_inputs(); rst_n = 1;
        for (int k = 1; k <= 4; k++) begin
            step(); e = sb.pop_front();
            checks++; if (PCF !== 32'(k * 4) || PCF !== e.pcf) begin failures++; $display("FAIL seq_pcf%0d got=%h exp=%h", k, PCF, k * 4); end
            checks++; if (PCD !== 32'((k - 1) * 4) || InstrD !== e.instrd || ValidD !== 1'b1) begin
                failures++; $display("FAIL seq_d%0d got pcd=%h instr=%h v=%b exp pcd=%h instr=%h v=1", k, PCD, InstrD, ValidD, (k - 1) * 4, e.instrd);
            end
        end
    endtask

    task automatic test_predict();
        Taken = 1; P_PC = 32'h100;
        step(); e = sb.pop_front();
        checks++; if (PCF !== 32'h100 || ValidD !== 1'b0 || PredCnt !== 16'd1 || InstrD !== NOP) begin
            failures++; $display("FAIL predict got pcf=%h v=%b pc=%0d instr=%h exp pcf=100 v=0 pc=1 instr=%h", PCF, ValidD, PredCnt, InstrD, NOP);
        end
        Taken = 0;
        step(); e = sb.pop_front();
        checks++; if (PCF !== 32'h104 || PCD !== 32'h100 || ValidD !== 1'b1 || InstrD !== imem(32'h100)) begin
            failures++; $display("FAIL predict_d got pcf=%h pcd=%h v=%b instr=%h exp 104/100/1/%h", PCF, PCD, ValidD, InstrD, imem(32'h100));
        end
    endtask

    task automatic test_stall_pending();
        logic [31:0] held;
        held = m_pc;
        StallF = 1; StallD = 1; Taken = 1; P_PC = 32'h200;
        step(); e = sb.pop_front();
        P_PC = 32'h300;
        step(); e = sb.pop_front();
        checks++; if (PCF !== held || PredCnt !== 16'd1) begin failures++; $display("FAIL stall_hold got pcf=%h pc=%0d exp %h/1", PCF, PredCnt, held); end
        StallF = 0; StallD = 0; Taken = 0;
        step(); e = sb.pop_front();
        checks++; if (PCF !== 32'h200 || PredCnt !== 16'd2 || ValidD !== 1'b0) begin
            failures++; $display("FAIL stall_release got pcf=%h pc=%0d v=%b exp 200/2/0", PCF, PredCnt, ValidD);
        end
        step(); e = sb.pop_front();
        checks++; if (PCF !== 32'h204 || PCD !== 32'h200 || ValidD !== 1'b1) begin
            failures++; $display("FAIL stall_after got pcf=%h pcd=%h v=%b exp 204/200/1", PCF, PCD, ValidD);
        end
    endtask

    task automatic test_mispred_pending();
        StallF = 1; Taken = 1; P_PC = 32'h500;
        step(); e = sb.pop_front();
        Taken = 0; MispredE = 1; PCRecoverE = 32'h40;
        step(); e = sb.pop_front();
        checks++; if (PCF !== 32'h40 || ValidD !== 1'b0 || MispredCnt !== 16'd1 || PredCnt !== e.pc) begin
            failures++; $display("FAIL mispred got pcf=%h v=%b mc=%0d pc=%0d exp 40/0/1/%0d", PCF, ValidD, MispredCnt, PredCnt, e.pc);
        end
        MispredE = 0; StallF = 0;
        step(); e = sb.pop_front();
        checks++; if (PCF !== 32'h44 || PredCnt !== e.pc) begin
            failures++; $display("FAIL mispred_drop got pcf=%h pc=%0d exp 44/%0d", PCF, PredCnt, e.pc);
        end
    endtask

    task automatic test_wrap();
        MispredE = 1; PCRecoverE = 32'hFFFFFFFC;
        step(); e = sb.pop_front();
        MispredE = 0;
        step(); e = sb.pop_front();
        checks++; if (PCF !== 32'd0 || PCD !== 32'hFFFFFFFC || PCPlus4D !== 32'd0 || MispredCnt !== 16'd2) begin
            failures++; $display("FAIL wrap got pcf=%h pcd=%h p4=%h mc=%0d exp 0/fffffffc/0/2", PCF, PCD, PCPlus4D, MispredCnt);
        end
    endtask

    task automatic test_flush_stalld();
        logic [31:0] pcd_h, p4_h;
        pcd_h = m_pcd; p4_h = m_pc4d;
        FlushD_BP = 1; StallD = 1;
        step(); e = sb.pop_front();
        checks++; if (ValidD !== 1'b0 || InstrD !== NOP || PCD !== pcd_h || PCPlus4D !== p4_h) begin
            failures++; $display("FAIL flush got v=%b instr=%h pcd=%h p4=%h exp 0/%h/%h/%h", ValidD, InstrD, PCD, PCPlus4D, NOP, pcd_h, p4_h);
        end
        FlushD_BP = 0; StallD = 0;
        step(); e = sb.pop_front();
        pcd_h = m_pcd;
        StallD = 1;
        step(); e = sb.pop_front();
        checks++; if (PCD !== pcd_h || ValidD !== 1'b1 || InstrD !== e.instrd || PCF !== e.pcf) begin
            failures++; $display("FAIL stalld got pcd=%h v=%b pcf=%h exp %h/1/%h", PCD, ValidD, PCF, pcd_h, e.pcf);
        end
        StallD = 0; FlushD = 1;
        step(); e = sb.pop_front();
        checks++; if (ValidD !== 1'b0 || InstrD !== NOP) begin failures++; $display("FAIL flushd got v=%b instr=%h exp 0/%h", ValidD, InstrD, NOP); end
        FlushD = 0;
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            StallF = ($urandom_range(0, 3) == 0); StallD = ($urandom_range(0, 4) == 0);
            FlushD = ($urandom_range(0, 9) == 0); FlushD_BP = ($urandom_range(0, 11) == 0);
            Taken = ($urandom_range(0, 3) == 0); P_PC = {$urandom_range(0, 255), 2'b00} << 4;
            MispredE = ($urandom_range(0, 12) == 0); PCRecoverE = $urandom & 32'hFFFFFFFC;
            step(); e = sb.pop_front();
            checks++;
            if (PCF !== e.pcf || PCD !== e.pcd || PCPlus4D !== e.pc4d || InstrD !== e.instrd ||
                ValidD !== e.valid || MispredCnt !== e.mc || PredCnt !== e.pc) begin
                failures++;
                $display("FAIL random%0d got %h %h %h %h %b %0d %0d exp %h %h %h %h %b %0d %0d", i,
                    PCF, PCD, PCPlus4D, InstrD, ValidD, MispredCnt, PredCnt,
                    e.pcf, e.pcd, e.pc4d, e.instrd, e.valid, e.mc, e.pc);
            end
        end
    endtask

    task automatic test_reset_mid();
        idle_inputs();
        step(); e = sb.pop_front();
        StallF = 1; StallD = 1; Taken = 1; P_PC = 32'h600;
        step(); e = sb.pop_front();
        rst_n = 0;
        step(); e = sb.pop_front();
        checks++; if (PCF !== 32'd0 || PCD !== 32'd0 || PCPlus4D !== 32'd0 || InstrD !== NOP || ValidD !== 1'b0 ||
                      MispredCnt !== 16'd0 || PredCnt !== 16'd0) begin
            failures++; $display("FAIL reset_mid got %h %h %h %h %b %0d %0d", PCF, PCD, PCPlus4D, InstrD, ValidD, MispredCnt, PredCnt);
        end
        idle_inputs(); rst_n = 1;
        step(); e = sb.pop_front();
        checks++; if (PCF !== 32'd4 || PredCnt !== 16'd0) begin failures++; $display("FAIL reset_resume got pcf=%h pc=%0d exp 4/0", PCF, PredCnt); end
    endtask

    initial begin
        idle_inputs(); rst_n = 0; InstrF = 32'd0;
        m_pc = 0; m_pcd = 0; m_pc4d = 0; m_instrd = NOP; m_valid = 0; m_pendv = 0; m_pendpc = 0; m_mc = 0; m_pcnt = 0;
        #2;
        test_reset();
        test_sequential();
        test_predict();
        test_stall_pending();
        test_mispred_pending();
        test_wrap();
        test_flush_stalld();
        test_random();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fetch_pc_unit.md
FETCH_PC_UNIT -- requirements
Module: fetch_pc_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h00000000, PCF value loaded on reset.
REQ-002 Parameter NOP_INSTR, default 32'h00000013, value loaded into InstrD on reset and on flush.
REQ-003 clk  in  1  sole clock; all state updates on its rising edge.
REQ-004 rst_n  in  1  reset, synchronous, active-low.
REQ-005 StallF  in  1  hold PCF (hazard unit).
REQ-006 StallD  in  1  hold IF/ID register.
REQ-007 FlushD  in  1  squash IF/ID (hazard unit).
REQ-008 FlushD_BP  in  1  squash IF/ID (branch predictor).
REQ-009 Taken  in  1  predictor says the branch in D is taken.
REQ-010 P_PC  in  32  predicted target for the branch in D.
REQ-011 MispredE  in  1  branch in E was mispredicted; recovery required.
REQ-012 PCRecoverE  in  32  correct PC after a misprediction.
REQ-013 InstrF  in  32  instruction read from imem at PCF.
REQ-014 PCF  out  32  fetch PC.
REQ-015 PCD  out  32  PC of the instruction in D.
REQ-016 PCPlus4D  out  32  PCD+4.
REQ-017 InstrD  out  32  instruction in D.
REQ-018 ValidD  out  1  InstrD is a real (non-squashed) instruction.
REQ-019 MispredCnt  out  16  count of recoveries taken.
REQ-020 PredCnt  out  16  count of predicted-taken redirects applied.

Function
REQ-021 PredReq SHALL be Taken & ValidD; combinational, one cycle.
REQ-022 Next-PC priority SHALL be MispredE -> PCRecoverE; else PendV & !StallF -> PendPC; else PredReq & !StallF -> P_PC; else !StallF -> PCF+4; else hold.
REQ-023 MispredE SHALL load PCF even when StallF=1.
REQ-024 PCF+4 and PCPlus4D SHALL wrap modulo 2^32 (32'hFFFFFFFC+4 = 0).
REQ-025 A one-entry redirect buffer (PendV, PendPC) SHALL capture P_PC when PredReq & StallF & !MispredE & !PendV.
REQ-026 PendV SHALL clear when PendPC is applied (first cycle with !StallF) or when MispredE=1; MispredE discards a pending target.
REQ-027 When PendV=1 and a new PredReq arrives, the buffer SHALL keep the older target and ignore the new one.
REQ-028 SquashD = FlushD | FlushD_BP | MispredE | (PredReq & !StallF) | (PendV & !StallF).
REQ-029 On SquashD, the IF/ID register SHALL load ValidD=0 and InstrD=NOP_INSTR, and SHALL hold PCD and PCPlus4D; squash overrides StallD.
REQ-030 Else if StallD, the IF/ID register SHALL hold all fields.
REQ-031 Else the IF/ID register SHALL load InstrD=InstrF, PCD=PCF, PCPlus4D=PCF+4, ValidD=1.
REQ-032 MispredCnt SHALL increment on each cycle with MispredE=1, saturating at 16'hFFFF.
REQ-033 PredCnt SHALL increment when P_PC or PendPC is loaded into PCF, saturating at 16'hFFFF.
REQ-034 Latency: a redirect at edge N SHALL make PCF equal the target after edge N; the target's instruction reaches D after edge N+1.

Reset
REQ-035 When rst_n=0 at an edge: PCF=RESET_PC, PCD=0, PCPlus4D=0, InstrD=NOP_INSTR, ValidD=0, PendV=0, PendPC=0, MispredCnt=0, PredCnt=0.
REQ-036 Reset SHALL override all stall, flush and redirect inputs, including mid-stall and with a pending redirect.
REQ-037 In the first cycle after reset release, sequential fetch from RESET_PC SHALL resume.

Verification
REQ-038 Reset, then 3 free cycles -> PCF 0,4,8,C; InstrD/PCD lag PCF by one cycle; ValidD=1 from the 2nd cycle.
REQ-039 ValidD=1, Taken=1, P_PC=32'h100 -> next PCF=32'h100, ValidD=0, PredCnt=1.
REQ-040 StallF=1 with Taken=1, P_PC=32'h200 for 2 cycles, then StallF=0 -> PCF held, then 32'h200; PredCnt=1.
REQ-041 PendV=1 and StallF=1, MispredE=1, PCRecoverE=32'h40 -> PCF=32'h40, PendV=0, MispredCnt=1, ValidD=0.
REQ-042 PCF=32'hFFFFFFFC, no stall -> PCF=0, PCPlus4D=0.
REQ-043 rst_n=0 asserted during StallD=1 with PendV=1 -> all outputs at REQ-035 values after the edge.
